md_unit: RTL and testbench



---
 rtl/md_unit.sv | 146 ++++++++++++++
 tb/tb_md_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit with a start/busy/done handshake.
// MUL/MULH/MULHSU/MULHU use radix-2 shift-add. DIV/DIVU/REM/REMU use restoring
// division. Both work on operand magnitudes, and the sign is fixed up in FIN.
// Optional build macro MD_EARLY_OUT_EN: multiplies with a zero operand complete
// at the start edge, the same way the divide special cases do.
module md_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] G
);

  localparam int unsigned CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   hi;     // product high half / partial remainder
  logic [XLEN-1:0]   lo;     // multiplier then product low half / dividend then quotient
  logic [XLEN-1:0]   bmag;   // multiplicand / divisor magnitude
  logic              neg;    // result needs negation in FIN
  logic [CW-1:0]     cnt;

  logic              sa_en, sb_en, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              special;
  logic [XLEN-1:0]   special_g;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   hi_next, lo_next;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   dres, dres_s, fin_g;

  // Decode operand signedness, magnitudes and the special cases that skip CALC
  always_comb begin
    sa_en     = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    sb_en     = op[2] ? ~op[0] : ~op[1];
    a_neg     = sa_en & A[XLEN-1];
    b_neg     = sb_en & B[XLEN-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    special   = 1'b0;
    special_g = '0;
    if (op[2] && B == '0) begin
      special   = 1'b1;
      special_g = op[1] ? A : '1;
    end else if (op[2] && !op[0] && A == {1'b1, {(XLEN-1){1'b0}}} && B == '1) begin
      special   = 1'b1;
      special_g = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`ifdef MD_EARLY_OUT_EN
    if (!op[2] && (A == '0 || B == '0)) begin
      special   = 1'b1;
      special_g = '0;
    end
`endif
  end

  // One iteration step (shift-add or restoring subtract) and the FIN sign fix-up
  always_comb begin
    mul_sum   = lo[0] ? ({1'b0, hi} + {1'b0, bmag}) : {1'b0, hi};
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, bmag};
    if (op_q[2]) begin
      hi_next = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod   = {hi, lo};
    prod_s = neg ? -prod : prod;
    dres   = op_q[1] ? hi : lo;
    dres_s = neg ? -dres : dres;
    if (op_q[2])
      fin_g = dres_s;
    else if (op_q[1:0] == 2'b00)
      fin_g = prod_s[XLEN-1:0];
    else
      fin_g = prod_s[2*XLEN-1:XLEN];
  end

  // Control FSM with registered busy/done/G
  // CALC holds ITER step cycles plus one final cycle that hands the result to FIN,
  // which gives the fixed 34-edge start-to-done latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      G     <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      bmag  <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            if (special) begin
              G    <= special_g;
              done <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              cnt   <= '0;
              hi    <= '0;
              lo    <= op[2] ? a_mag : b_mag;
              bmag  <= op[2] ? b_mag : a_mag;
              neg   <= (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
            end
          end
        end
        CALC: begin
          if (cnt == CW'(ITER)) begin
            state <= FIN;
          end else begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          G     <= fin_g;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit. It runs directed test-plan cases,
// handshake corner cases and randomized operations. The results are checked
// against a 64-bit arithmetic reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] G;

  int checks = 0;
  int errors = 0;

  md_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .G(G)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic on sign/zero-extended operands
  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    longint      q;
    sa = {{32{a[31]}}, a};
    ua = {32'b0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        q = $signed(sa) / $signed(sb);
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        q = $signed(sa) % $signed(sb);
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges after the start edge until done is visible: 0 for bypass cases, else 34
  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 0;
    if (o[2] && !o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
`ifdef MD_EARLY_OUT_EN
    if (!o[2] && (a == 0 || b == 0)) return 0;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // The bench always sits 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    step();
    start = 1'b0;
    op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  // Wait (bounded) for done; inj_k >= 0 pulses an extra start at that cycle
  task automatic wait_done(input string tag, input logic [31:0] exp_g, input int exp_k, input int inj_k);
    int k = 0;
    int busy_lo = 0;
    while (!done && k < 60) begin
      if (!busy) busy_lo++;
      if (k == inj_k) begin
        op = 3'b100; A = 32'd9; B = 32'd3; start = 1'b1;
      end
      step();
      start = 1'b0;
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(k), 32'(exp_k));
    check({tag, "_G"}, G, exp_g);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (exp_k > 0) check({tag, "_busy_low_cycles"}, 32'(busy_lo), 32'd0);
  endtask

  task automatic idle_check(input string tag);
    step();
    check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b, g;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_G", G, 32'd0);
    rst = 1'b0;
    step();

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,        32'd14};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,        32'd2};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,        32'd5};
    vecs[10] = '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0};
    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b);
      wait_done($sformatf("dir%0d", i), vecs[i].g, ref_lat(vecs[i].o, vecs[i].a, vecs[i].b), -1);
      idle_check($sformatf("dir%0d", i));
    end

    // start while busy is ignored, then a zero-bubble start in the done cycle
    issue(3'd0, 32'd3, 32'd4);
    wait_done("ignored_start", 32'd12, 34, 5);
    issue(3'd5, 32'd9, 32'd3);
    wait_done("back_to_back", 32'd3, 34, -1);
    idle_check("back_to_back");

    // reset mid-operation aborts without a done pulse
    issue(3'd5, 32'd1000, 32'd10);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_G", G, 32'd0);
    done_cnt = 0;
    repeat (40) begin
      step();
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    issue(3'd0, 32'd6, 32'd7);
    wait_done("mul_after_abort", 32'd42, 34, -1);
    issue(3'd0, 32'd0, 32'd5);
    wait_done("mul_zero", 32'd0, ref_lat(3'd0, 32'd0, 32'd5), -1);
    idle_check("mul_zero");

    // rst and start together: rst wins
    op = 3'd0; A = 32'd2; B = 32'd3; start = 1'b1; rst = 1'b1;
    step();
    start = 1'b0; rst = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_done", 32'(done), 32'd0);
    step();
    check("rst_start_idle", 32'(busy), 32'd0);

    // randomized operations, sometimes back-to-back
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb);
      wait_done($sformatf("rnd%0d_op%0d_%h_%h", n, ro, ra, rb), ref_md(ro, ra, rb), ref_lat(ro, ra, rb), -1);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
